// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Scanner FSM state encoding and index/code width helpers.
// Revision : 1.0
// ============================================================================
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_EMIT     = 3'd3,
        ST_HOLD     = 3'd4,
        ST_REL_DB   = 3'd5,
        ST_EMIT_REL = 3'd6
    } kstate_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int code_width(input int rows, input int cols);
        return idx_width(rows * cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// ============================================================================
// Module   : key_sync
// Brief    : Two-flop synchroniser for asynchronous row sense lines.
// Revision : 1.0
// ============================================================================
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module   : matrix_key_scanner
// Brief    : Column-scanned key matrix with debounce and valid/ready events.
//            Define KEY_RELEASE_EVENT_EN to also report key releases.
// Revision : 1.0
// ============================================================================
module matrix_key_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 3,
    parameter int COLS            = 3,
    parameter int SCAN_DWELL      = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ROWS-1:0]                     row_in,
    output logic [COLS-1:0]                     col_drive,
    output logic                                key_valid,
    input  logic                                key_ready,
    output logic [code_width(ROWS, COLS)-1:0]   key_code,
    output logic                                key_release
);

    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int ROW_W  = idx_width(ROWS);
    localparam int COL_W  = idx_width(COLS);
    localparam int DW_W   = idx_width(SCAN_DWELL);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DWELL - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [7:0]       DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);

    kstate_e             state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [7:0]          db_q, db_d;
    logic [ROWS-1:0]     rs;
    logic [ROW_W-1:0]    first_row;

    key_sync #(
        .WIDTH   (ROWS)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (row_in),
        .sync_o  (rs)
    );

    // Lowest-numbered active row wins when several rows respond together.
    always_comb begin
        first_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (rs[r]) first_row = ROW_W'(r);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            code_q  <= '0;
            dwell_q <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            dwell_q <= dwell_d;
            db_q    <= db_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        unique case (state_q)
            ST_IDLE: begin
                col_d   = '0;
                dwell_d = '0;
                db_d    = '0;
                if (rs != '0) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                // Sample only in the last dwell cycle so the synchroniser has caught up.
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs != '0) begin
                        row_d   = first_row;
                        code_d  = CODE_W'(int'(first_row) * COLS + int'(col_q));
                        db_d    = '0;
                        state_d = ST_DEBOUNCE;
                    end else if (col_q == COL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (rs[row_q]) begin
                    if (db_q == DB_LAST) begin
                        db_d    = '0;
                        state_d = ST_EMIT;
                    end else begin
                        db_d = db_q + 8'd1;
                    end
                end else begin
                    db_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (key_ready) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                db_d = '0;
                if (!rs[row_q]) state_d = ST_REL_DB;
            end
            ST_REL_DB: begin
                if (!rs[row_q]) begin
                    if (db_q == DB_LAST) begin
                        db_d = '0;
`ifdef KEY_RELEASE_EVENT_EN
                        state_d = ST_EMIT_REL;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        db_d = db_q + 8'd1;
                    end
                end else begin
                    db_d    = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_EMIT_REL: begin
`ifdef KEY_RELEASE_EVENT_EN
                if (key_ready) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col_drive[c] = (state_q == ST_IDLE) ? 1'b1 : (col_q == COL_W'(c));
        end
        key_code = code_q;
`ifdef KEY_RELEASE_EVENT_EN
        key_valid   = (state_q == ST_EMIT) || (state_q == ST_EMIT_REL);
        key_release = (state_q == ST_EMIT_REL);
`else
        key_valid   = (state_q == ST_EMIT);
        key_release = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_key_scanner
// Brief    : Directed self-checking bench for a 3x3 matrix_key_scanner.
// Revision : 1.0
// ============================================================================
module tb_matrix_key_scanner;

`ifdef KEY_RELEASE_EVENT_EN
    localparam int REL_EN = 1;
`else
    localparam int REL_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] row_in;
    logic [2:0] col_drive;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;
    logic       key_release;
    logic [8:0] keys;

    typedef struct {
        logic [3:0] code;
        logic       rel;
    } ev_t;

    typedef struct {
        int row;
        int col;
        int hold;
        int exp_code;
    } vec_t;

    ev_t  evq[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    matrix_key_scanner #(
        .ROWS            (3),
        .COLS            (3),
        .SCAN_DWELL      (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_in      (row_in),
        .col_drive   (col_drive),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_release (key_release)
    );

    // Key k = row*3 + col connects column drive col to row sense row.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 3; r++) row_in[r] = |(keys[r*3 +: 3] & col_drive);
    end

    // Inputs only change 2 time units after a rising edge, so negedge values hold through the next edge.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            ev_t e;
            e.code = key_code;
            e.rel  = key_release;
            evq.push_back(e);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int count_press(input int code);
        int n = 0;
        foreach (evq[i]) if (!evq[i].rel && evq[i].code == 4'(code)) n++;
        return n;
    endfunction

    task automatic wait_valid(input string name);
        int cyc = 0;
        while (!key_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check(name, int'(key_valid), 1);
    endtask

    initial begin
        int bad;

        vecs[0] = '{row: 1, col: 2, hold: 40, exp_code: 5};
        vecs[1] = '{row: 0, col: 0, hold: 40, exp_code: 0};
        vecs[2] = '{row: 2, col: 2, hold: 40, exp_code: 8};
        vecs[3] = '{row: 0, col: 1, hold: 25, exp_code: 1};
        vecs[4] = '{row: 2, col: 0, hold: 30, exp_code: 6};
        vecs[5] = '{row: 0, col: 2, hold: 40, exp_code: 2};

        rst_n     = 1'b0;
        key_ready = 1'b1;
        keys      = '0;
        tick(3);
        check("reset_col_drive", int'(col_drive), 7);
        check("reset_key_valid", int'(key_valid), 0);
        check("reset_key_code", int'(key_code), 0);
        check("reset_key_release", int'(key_release), 0);
        rst_n = 1'b1;
        tick(5);

        // Single clean presses, each followed by release.
        for (int i = 0; i < 6; i++) begin
            evq.delete();
            keys = 9'd1 << (vecs[i].row * 3 + vecs[i].col);
            tick(vecs[i].hold);
            keys = '0;
            tick(60);
            check($sformatf("vec%0d_count", i), evq.size(), 1 + REL_EN);
            if (evq.size() > 0) begin
                check($sformatf("vec%0d_code", i), int'(evq[0].code), vecs[i].exp_code);
                check($sformatf("vec%0d_press_flag", i), int'(evq[0].rel), 0);
            end
`ifdef KEY_RELEASE_EVENT_EN
            if (evq.size() > 1) begin
                check($sformatf("vec%0d_rel_code", i), int'(evq[1].code), vecs[i].exp_code);
                check($sformatf("vec%0d_rel_flag", i), int'(evq[1].rel), 1);
            end
`endif
        end

        // 3-cycle glitch on key 0 must be rejected.
        evq.delete();
        keys = 9'd1;
        tick(3);
        keys = '0;
        tick(40);
        check("glitch_events", evq.size(), 0);
        check("glitch_idle_cols", int'(col_drive), 7);

        // Stalled consumer on key 7; key released mid-stall.
        evq.delete();
        key_ready = 1'b0;
        keys      = 9'd1 << 7;
        wait_valid("stall_valid_seen");
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) keys = '0;
            tick();
            if (!key_valid || key_code != 4'd7) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_no_transfer", evq.size(), 0);
        key_ready = 1'b1;
        tick();
        check("stall_transfers", evq.size(), 1);
        check("stall_valid_drop", int'(key_valid), 0);
        if (evq.size() > 0) check("stall_code", int'(evq[0].code), 7);
        tick(40);

        // Keys 4 and 8 together: 4 first, 8 only after 4 is released.
        evq.delete();
        keys = (9'd1 << 4) | (9'd1 << 8);
        tick(60);
        check("multi_press4", count_press(4), 1);
        check("multi_no8_yet", count_press(8), 0);
        keys = 9'd1 << 8;
        tick(60);
        check("multi_press8_after", count_press(8), 1);
        check("multi_total", evq.size(), 2 + REL_EN);
        keys = '0;
        tick(60);

        // Reset while an event is pending.
        evq.delete();
        key_ready = 1'b0;
        keys      = 9'd1 << 3;
        wait_valid("rst_valid_seen");
        rst_n = 1'b0;
        keys  = '0;
        tick();
        check("rst_mid_valid", int'(key_valid), 0);
        check("rst_mid_cols", int'(col_drive), 7);
        check("rst_mid_code", int'(key_code), 0);
        rst_n     = 1'b1;
        key_ready = 1'b1;
        tick(60);
        check("rst_mid_no_event", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
